// File: rtl/matmul_job_sched_if.sv
// -----------------------------------------------------------------------------
// matmul_job_sched_if
// Job submission and completion channel between a job producer and the
// matmul job scheduler.
//   job_valid/job_ready     valid/ready handshake for one job
//   job_mode, job_size      multiply mode (1 = AS, 2 = SA) and MATRIX_SIZE
//   job_base_sp/hash/b      base addresses handed to mem_ctrl on launch
//   job_id                  tag echoed back on completion
//   done_valid              1-cycle completion strobe
//   done_id, done_err       tag and error status of the completed job
// Modports: master = job producer, slave = scheduler.
// -----------------------------------------------------------------------------
interface matmul_job_sched_if #(
    parameter int ID_W = 4
);
    logic            job_valid;
    logic            job_ready;
    logic [2:0]      job_mode;
    logic [10:0]     job_size;
    logic [31:0]     job_base_sp;
    logic [31:0]     job_base_hash;
    logic [31:0]     job_base_b;
    logic [ID_W-1:0] job_id;
    logic            done_valid;
    logic [ID_W-1:0] done_id;
    logic            done_err;

    modport master (
        output job_valid, job_mode, job_size, job_base_sp, job_base_hash,
               job_base_b, job_id,
        input  job_ready, done_valid, done_id, done_err
    );

    modport slave (
        input  job_valid, job_mode, job_size, job_base_sp, job_base_hash,
               job_base_b, job_id,
        output job_ready, done_valid, done_id, done_err
    );
endinterface

// File: rtl/matmul_job_sched.sv
// -----------------------------------------------------------------------------
// matmul_job_sched
// Job queue and launch sequencer for the systolic memory controller.
// Jobs arrive over the job interface and are buffered in a DEPTH-entry FIFO.
// The head job is launched with a single-cycle calc_init pulse; its config is
// held in registers until the next launch. Completion is tracked through the
// mem_ctrl state, and each job ends with a done strobe carrying its tag and an
// error flag (invalid job, start timeout or run timeout).
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   job             slave side of matmul_job_sched_if (submit + completion)
//   flush           drop all queued jobs that have not been launched
//   hash_ready      HASH source ready, only gates a launch from idle
//   ctrl_state      mem_ctrl current_state, 0 = IDLE
//   calc_init       1-cycle launch pulse
//   mem_mode, matrix_size, base_sp, base_hash, base_b   launched job config
//   busy            sequencer active or jobs pending
// -----------------------------------------------------------------------------
module matmul_job_sched #(
    parameter int DEPTH       = 4,
    parameter int ID_W        = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    matmul_job_sched_if.slave    job,
    input  logic                 flush,
    input  logic                 hash_ready,
    input  logic [3:0]           ctrl_state,
    output logic                 calc_init,
    output logic [2:0]           mem_mode,
    output logic [10:0]          matrix_size,
    output logic [31:0]          base_sp,
    output logic [31:0]          base_hash,
    output logic [31:0]          base_b,
    output logic                 busy
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int RUN_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int RUN_LAST = TIMEOUT_CYC - 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // A job is runnable only in AS or SA mode with a non-zero size.
    function automatic logic job_is_valid(input logic [2:0] mode, input logic [10:0] size);
        return ((mode == 3'd1) || (mode == 3'd2)) && (size != 11'd0);
    endfunction

    // FIFO storage
    logic [2:0]      mode_mem_r [DEPTH];
    logic [10:0]     size_mem_r [DEPTH];
    logic [31:0]     sp_mem_r   [DEPTH];
    logic [31:0]     hash_mem_r [DEPTH];
    logic [31:0]     b_mem_r    [DEPTH];
    logic [ID_W-1:0] id_mem_r   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
    logic [CNT_W-1:0] count_r, count_next_s;
    logic             full_s, empty_s, push_s, pop_s, job_ready_s;

    state_t           state_r, state_next_s;
    logic             term_err_s;
    logic [1:0]       wait_cnt_r;
    logic [RUN_W-1:0] run_cnt_r;

    logic             calc_init_r, calc_init_next_s;
    logic             done_valid_r, done_valid_next_s;
    logic [ID_W-1:0]  done_id_r;
    logic             done_err_r;
    logic             busy_r, busy_next_s;
    logic             load_cfg_s;

    logic [2:0]       mem_mode_r;
    logic [10:0]      matrix_size_r;
    logic [31:0]      base_sp_r, base_hash_r, base_b_r;

    assign full_s      = (count_r == CNT_W'(DEPTH));
    assign empty_s     = (count_r == {CNT_W{1'b0}});
    // flush drops a simultaneous push, so ready is withheld in that cycle.
    assign job_ready_s = !full_s && !flush;
    assign push_s      = job.job_valid && job_ready_s;
    assign pop_s       = (state_r == S_DONE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic and termination status of the job entering S_DONE
    always_comb begin
        state_next_s = state_r;
        term_err_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                // A flush in idle empties the queue, so nothing is launched.
                if (flush || empty_s) begin
                    state_next_s = S_IDLE;
                end else if (!job_is_valid(mode_mem_r[rd_ptr_r], size_mem_r[rd_ptr_r])) begin
                    state_next_s = S_DONE;
                    term_err_s   = 1'b1;
                end else if (hash_ready) begin
                    state_next_s = S_LAUNCH;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_LAUNCH: begin
                state_next_s = S_WAIT;
            end
            S_WAIT: begin
                if (ctrl_state != 4'd0) begin
                    state_next_s = S_RUN;
                end else if (wait_cnt_r == 2'd3) begin
                    state_next_s = S_DONE;
                    term_err_s   = 1'b1;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_RUN: begin
                // Normal completion takes priority over a coincident timeout.
                if (ctrl_state == 4'd0) begin
                    state_next_s = S_DONE;
                    term_err_s   = 1'b0;
                end else if (run_cnt_r == RUN_W'(RUN_LAST)) begin
                    state_next_s = S_DONE;
                    term_err_s   = 1'b1;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DONE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // FSM outputs, computed from the next state so they can be registered
    always_comb begin
        calc_init_next_s  = (state_next_s == S_LAUNCH);
        done_valid_next_s = (state_next_s == S_DONE);
        load_cfg_s        = (state_r == S_IDLE) && (state_next_s == S_LAUNCH);
        busy_next_s       = (state_next_s != S_IDLE) || (count_next_s != {CNT_W{1'b0}});
    end

    // FIFO pointer and occupancy update; a launched head survives a flush
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_W'(1'b1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        if (flush) begin
            if ((state_r != S_IDLE) && !pop_s) begin
                wr_ptr_next_s = rd_ptr_r + PTR_W'(1'b1);
                count_next_s  = CNT_W'(1'b1);
            end else begin
                wr_ptr_next_s = rd_ptr_next_s;
                count_next_s  = {CNT_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                wr_ptr_next_s = wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CNT_W'(1'b1);
                2'b01:   count_next_s = count_r - CNT_W'(1'b1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // FIFO pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
        end
    end

    // FIFO entry write at the tail
    always_ff @(posedge clk) begin
        if (push_s) begin
            mode_mem_r[wr_ptr_r] <= job.job_mode;
            size_mem_r[wr_ptr_r] <= job.job_size;
            sp_mem_r[wr_ptr_r]   <= job.job_base_sp;
            hash_mem_r[wr_ptr_r] <= job.job_base_hash;
            b_mem_r[wr_ptr_r]    <= job.job_base_b;
            id_mem_r[wr_ptr_r]   <= job.job_id;
        end
    end

    // Launched-job config, loaded from the head on entry to S_LAUNCH
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_mode_r    <= 3'd0;
            matrix_size_r <= 11'd0;
            base_sp_r     <= 32'd0;
            base_hash_r   <= 32'd0;
            base_b_r      <= 32'd0;
        end else if (load_cfg_s) begin
            mem_mode_r    <= mode_mem_r[rd_ptr_r];
            matrix_size_r <= size_mem_r[rd_ptr_r];
            base_sp_r     <= sp_mem_r[rd_ptr_r];
            base_hash_r   <= hash_mem_r[rd_ptr_r];
            base_b_r      <= b_mem_r[rd_ptr_r];
        end
    end

    // Start/run watchdog counters; each clears whenever its state is left
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 2'd0;
            run_cnt_r  <= {RUN_W{1'b0}};
        end else begin
            wait_cnt_r <= (state_r == S_WAIT) ? (wait_cnt_r + 2'd1) : 2'd0;
            run_cnt_r  <= (state_r == S_RUN) ? (run_cnt_r + RUN_W'(1'b1)) : {RUN_W{1'b0}};
        end
    end

    // Registered launch/completion/busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            calc_init_r  <= 1'b0;
            done_valid_r <= 1'b0;
            done_id_r    <= {ID_W{1'b0}};
            done_err_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            calc_init_r  <= calc_init_next_s;
            done_valid_r <= done_valid_next_s;
            done_id_r    <= done_valid_next_s ? id_mem_r[rd_ptr_r] : {ID_W{1'b0}};
            done_err_r   <= done_valid_next_s && term_err_s;
            busy_r       <= busy_next_s;
        end
    end

    assign job.job_ready  = job_ready_s;
    assign job.done_valid = done_valid_r;
    assign job.done_id    = done_id_r;
    assign job.done_err   = done_err_r;
    assign calc_init      = calc_init_r;
    assign mem_mode       = mem_mode_r;
    assign matrix_size    = matrix_size_r;
    assign base_sp        = base_sp_r;
    assign base_hash      = base_hash_r;
    assign base_b         = base_b_r;
    assign busy           = busy_r;
endmodule
